// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Iterative restoring unsigned divider producing one quotient bit per clock.
// It is the inverse of the vedic multiplier family: given a product and one
// factor it recovers the other factor, for example p / b -> a.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operands present on dividend/divisor
//   in_ready     divider idle and able to accept operands
//   dividend     unsigned dividend  [WIDTH-1:0]
//   divisor      unsigned divisor   [WIDTH-1:0]
//   out_valid    result present on quotient/remainder/div_by_zero
//   out_ready    consumer accepts the result
//   quotient     unsigned quotient  [WIDTH-1:0]
//   remainder    unsigned remainder [WIDTH-1:0]
//   div_by_zero  result came from a zero divisor (quotient all ones,
//                remainder = dividend)
//
// Parameters
//   WIDTH        operand/result width, 2..32
//
// Optional build macro
//   SEQ_DIVIDER_EARLY_EXIT_EN  when defined, a non-zero divisor larger than
//                              the dividend finishes at the accept edge
//                              (quotient 0, remainder = dividend) instead of
//                              running the full WIDTH-cycle iteration.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q,   dvd_d;
    logic [WIDTH-1:0]   dvs_q,   dvs_d;
    logic [WIDTH-1:0]   rem_q,   rem_d;
    logic [WIDTH-1:0]   quot_q,  quot_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               dbz_q,   dbz_d;

    logic [WIDTH:0]     r_shift;
    logic [WIDTH-1:0]   r_sub;
    logic               q_bit;
    logic               early_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        // The stored partial remainder is always below the divisor, so only
        // the shifted value needs the extra bit. When the compare succeeds the
        // difference is again below the divisor and fits in WIDTH bits, which
        // makes the truncated subtraction exact.
        r_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit   = (r_shift >= {1'b0, dvs_q});
        r_sub   = r_shift[WIDTH-1:0] - dvs_q;

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
        early_exit = (dividend < divisor);
`else
        early_exit = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    quot_d  = '0;
                    dbz_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = CALC;
                    if (divisor == '0) begin
                        // Zero divisor bypasses the iteration entirely.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else if (early_exit) begin
                        rem_d   = dividend;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                rem_d  = q_bit ? r_sub : r_shift[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], q_bit};
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
